// File: rtl/exec_ctrl_pkg.sv
// Shared types and constants for the execution step controller: FSM state
// encoding, default tick dividers and the speed-code to period mapping.
package exec_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_HALTED  = 2'd1,
    ST_RUNNING = 2'd2,
    ST_STEP    = 2'd3
  } state_e;

  localparam int unsigned DIV0_DEF = 16;
  localparam int unsigned DIV1_DEF = 50000;
  localparam int unsigned DIV2_DEF = 500000;
  localparam int unsigned DIV3_DEF = 5000000;
  localparam int unsigned DIV4_DEF = 50000000;

  // Codes 0..3 select their own divider; every code from 4 upward is the slowest.
  function automatic logic [31:0] speed_period(input logic [3:0]  speed,
                                               input logic [31:0] d0,
                                               input logic [31:0] d1,
                                               input logic [31:0] d2,
                                               input logic [31:0] d3,
                                               input logic [31:0] d4);
    logic [31:0] p;
    case (speed)
      4'd0:    p = d0;
      4'd1:    p = d1;
      4'd2:    p = d2;
      4'd3:    p = d3;
      default: p = d4;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/exec_step_controller_rise_detect.sv
// One-bit rising-edge detector. The history register is loaded from the input
// during reset as well, so a level held high through reset is not an edge.
module rise_detect (
  input  logic clk_i,
  input  logic n_reset_i,
  input  logic d_i,
  output logic rise_o
);

  logic prev_q;

  // History register: tracks the input in reset and in normal operation alike.
  always_ff @(posedge clk_i) begin
    if (!n_reset_i) prev_q <= d_i;
    else            prev_q <= d_i;
  end

  assign rise_o = n_reset_i & d_i & ~prev_q;

endmodule

// File: rtl/exec_step_controller.sv
// Execution step controller: produces single-cycle cpu_tick enables at a
// speed-selected rate and sequences init / run / halt / single-step.
// All outputs come straight from registers.
module exec_step_controller
  import exec_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W    = 32,
  parameter bit          AUTO_RUN = 1'b1,
  parameter int unsigned DIV0     = DIV0_DEF,
  parameter int unsigned DIV1     = DIV1_DEF,
  parameter int unsigned DIV2     = DIV2_DEF,
  parameter int unsigned DIV3     = DIV3_DEF,
  parameter int unsigned DIV4     = DIV4_DEF
) (
  input  logic             physical_clock,
  input  logic             n_reset,
  input  logic [3:0]       speed_sel,
  input  logic             run_req,
  input  logic             halt_req,
  input  logic             step_req,
  input  logic             halt_instr,
  output logic             cpu_tick,
  output logic             init_flag,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] cycle_count
);

  state_e           state_q, state_d;
  logic             tick_q, tick_d;
  logic             init_q, init_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      div_q, div_d;
  logic [31:0]      period;
  logic             due;
  logic             run_rise, halt_rise, step_rise;

  rise_detect u_run_rise (
    .clk_i(physical_clock), .n_reset_i(n_reset), .d_i(run_req), .rise_o(run_rise)
  );
  rise_detect u_halt_rise (
    .clk_i(physical_clock), .n_reset_i(n_reset), .d_i(halt_req), .rise_o(halt_rise)
  );
  rise_detect u_step_rise (
    .clk_i(physical_clock), .n_reset_i(n_reset), .d_i(step_req), .rise_o(step_rise)
  );

  // Period follows speed_sel every cycle; '>=' lets a faster code applied
  // mid-count fire on the next cycle instead of running the counter past it.
  assign period = speed_period(speed_sel, 32'(DIV0), 32'(DIV1), 32'(DIV2),
                               32'(DIV3), 32'(DIV4));
  assign due    = (div_q >= period - 32'd1);

  // State register; reset aborts any count and any pending tick.
  always_ff @(posedge physical_clock) begin
    if (!n_reset) begin
      state_q <= ST_INIT;
      tick_q  <= 1'b0;
      init_q  <= 1'b0;
      cnt_q   <= '0;
      div_q   <= '0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      init_q  <= init_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
    end
  end

  // Next-state and tick generation.
  always_comb begin
    state_d = state_q;
    tick_d  = 1'b0;
    init_d  = init_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    case (state_q)
      ST_INIT: begin
        // First cycle issues the uncounted init tick, the next one leaves INIT.
        if (!tick_q) begin
          tick_d = 1'b1;
        end else begin
          init_d  = 1'b1;
          state_d = AUTO_RUN ? ST_RUNNING : ST_HALTED;
          div_d   = '0;
        end
      end
      ST_RUNNING: begin
        if (halt_rise) begin
          state_d = ST_HALTED;
          div_d   = '0;
        end else if (tick_q && halt_instr) begin
          state_d = ST_HALTED;
          div_d   = '0;
        end else if (due) begin
          tick_d = 1'b1;
          div_d  = '0;
          cnt_d  = cnt_q + CNT_W'(1);
        end else begin
          div_d = div_q + 32'd1;
        end
      end
      ST_HALTED: begin
        if (run_rise) begin
          state_d = ST_RUNNING;
          div_d   = '0;
        end else if (step_rise) begin
          state_d = ST_STEP;
          tick_d  = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      ST_STEP: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  assign cpu_tick    = tick_q;
  assign init_flag   = init_q;
  assign state       = state_q;
  assign cycle_count = cnt_q;

endmodule

// File: tb/tb_exec_step_controller.sv
// Directed bench for exec_step_controller. The driver pushes each expected
// tick (cycle, count, state) into exp_q; a monitor pops one entry on every
// cpu_tick and compares. Level checks are made directly by the driver.
module tb_exec_step_controller;

  logic       physical_clock = 1'b0;
  logic       n_reset;
  logic [3:0] speed_sel;
  logic       run_req, halt_req, step_req, halt_instr;

  logic       tick_a, init_a;
  logic [1:0] state_a;
  logic [3:0] count_a;
  logic       tick_b, init_b;
  logic [1:0] state_b;
  logic [3:0] count_b;

  int         cyc = 0;
  int         tests = 0;
  int         fails = 0;
  int         b_ticks = 0;
  int         t0, h, r, s;

  // {cycle[31:0], count[3:0], state[1:0]}
  logic [37:0] exp_q[$];

  exec_step_controller #(.CNT_W(4), .AUTO_RUN(1'b1), .DIV4(32)) dut_a (
    .physical_clock(physical_clock), .n_reset(n_reset), .speed_sel(speed_sel),
    .run_req(run_req), .halt_req(halt_req), .step_req(step_req),
    .halt_instr(halt_instr), .cpu_tick(tick_a), .init_flag(init_a),
    .state(state_a), .cycle_count(count_a)
  );

  exec_step_controller #(.CNT_W(4), .AUTO_RUN(1'b0), .DIV4(32)) dut_b (
    .physical_clock(physical_clock), .n_reset(n_reset), .speed_sel(speed_sel),
    .run_req(run_req), .halt_req(halt_req), .step_req(step_req),
    .halt_instr(halt_instr), .cpu_tick(tick_b), .init_flag(init_b),
    .state(state_b), .cycle_count(count_b)
  );

  // Clock and cycle index (cyc = number of posedges so far).
  always #5 physical_clock = ~physical_clock;
  always @(posedge physical_clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_tick(input int at, input logic [3:0] cnt, input logic [1:0] st);
    exp_q.push_back({at[31:0], cnt, st});
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge physical_clock);
  endtask

  // Scoreboard monitor for dut_a ticks.
  always @(negedge physical_clock) begin
    if (tick_a) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_tick: got tick at cycle %0d expected none", cyc);
      end else begin
        logic [37:0] e;
        e = exp_q.pop_front();
        check("tick_cycle", cyc, e[37:6]);
        check("tick_count", {28'd0, count_a}, {28'd0, e[5:2]});
        check("tick_state", {30'd0, state_a}, {30'd0, e[1:0]});
      end
    end
    if (tick_b) b_ticks++;
  end

  initial begin
    n_reset = 1'b0; speed_sel = 4'd0;
    run_req = 1'b0; halt_req = 1'b0; step_req = 1'b1; halt_instr = 1'b0;

    // Reset state (step_req held high through reset).
    wait_until(1);
    check("rst_state", {30'd0, state_a}, 0);
    check("rst_tick", {31'd0, tick_a}, 0);
    check("rst_init", {31'd0, init_a}, 0);
    check("rst_count", {28'd0, count_a}, 0);

    // 1: release, init tick, then runs at 16 cycles per tick.
    wait_until(3);
    t0 = cyc;
    n_reset = 1'b1;
    expect_tick(t0 + 1, 4'd0, 2'd0);
    expect_tick(t0 + 18, 4'd1, 2'd2);
    expect_tick(t0 + 34, 4'd2, 2'd2);
    expect_tick(t0 + 50, 4'd3, 2'd2);
    expect_tick(t0 + 66, 4'd4, 2'd2);
    wait_until(t0 + 1);
    check("init_flag_during_init_tick", {31'd0, init_a}, 0);
    wait_until(t0 + 2);
    check("init_flag_set", {31'd0, init_a}, 1);
    check("state_after_init", {30'd0, state_a}, 2);
    check("b_state_after_init", {30'd0, state_b}, 1);
    check("b_init_flag", {31'd0, init_b}, 1);
    wait_until(t0 + 66);
    check("count_after_4", {28'd0, count_a}, 4);
    check("b_no_step_after_reset", b_ticks, 1);
    check("b_still_halted", {30'd0, state_b}, 1);
    step_req = 1'b0;

    // 2: halt edge in the cycle before a due tick suppresses it.
    wait_until(t0 + 81);
    halt_req = 1'b1;
    wait_until(t0 + 82);
    halt_req = 1'b0;
    check("halt_state", {30'd0, state_a}, 1);
    check("halt_count_held", {28'd0, count_a}, 4);
    check("halt_no_tick", {31'd0, tick_a}, 0);
    h = t0 + 90;
    wait_until(h);
    step_req = 1'b1;
    expect_tick(h + 1, 4'd5, 2'd3);
    wait_until(h + 2);
    step_req = 1'b0;
    check("step_back_to_halted", {30'd0, state_a}, 1);
    check("step_tick_one_cycle", {31'd0, tick_a}, 0);

    // 3: run, then halt_instr coincident with a tick.
    r = t0 + 100;
    wait_until(r);
    run_req = 1'b1;
    expect_tick(r + 17, 4'd6, 2'd2);
    wait_until(r + 3);
    run_req = 1'b0;
    wait_until(r + 16);
    halt_instr = 1'b1;
    wait_until(r + 18);
    halt_instr = 1'b0;
    check("halt_instr_state", {30'd0, state_a}, 1);
    wait_until(r + 1018);
    check("halt_instr_quiet_state", {30'd0, state_a}, 1);
    check("halt_instr_quiet_count", {28'd0, count_a}, 6);

    // 5: run and step edges together while halted: run wins.
    s = r + 1020;
    wait_until(s);
    run_req = 1'b1;
    step_req = 1'b1;
    expect_tick(s + 17, 4'd7, 2'd2);
    wait_until(s + 1);
    check("run_wins_state", {30'd0, state_a}, 2);
    check("run_wins_no_tick", {31'd0, tick_a}, 0);
    wait_until(s + 3);
    run_req = 1'b0;
    step_req = 1'b0;

    // 4: speed 1, switch to speed 0 when the divider count reaches 20000.
    wait_until(s + 17);
    speed_sel = 4'd1;
    expect_tick(s + 20018, 4'd8, 2'd2);
    expect_tick(s + 20034, 4'd9, 2'd2);
    expect_tick(s + 20050, 4'd10, 2'd2);
    wait_until(s + 20017);
    speed_sel = 4'd0;
    wait_until(s + 20050);
    speed_sel = 4'd9;
    expect_tick(s + 20082, 4'd11, 2'd2);
    expect_tick(s + 20114, 4'd12, 2'd2);
    wait_until(s + 20114);
    speed_sel = 4'd0;

    // 6: counter wraps after 17 counted ticks, then reset mid-count.
    expect_tick(s + 20130, 4'd13, 2'd2);
    expect_tick(s + 20146, 4'd14, 2'd2);
    expect_tick(s + 20162, 4'd15, 2'd2);
    expect_tick(s + 20178, 4'd0, 2'd2);
    expect_tick(s + 20194, 4'd1, 2'd2);
    wait_until(s + 20194);
    check("count_wrapped", {28'd0, count_a}, 1);
    wait_until(s + 20209);
    n_reset = 1'b0;
    wait_until(s + 20210);
    check("midrst_state", {30'd0, state_a}, 0);
    check("midrst_init", {31'd0, init_a}, 0);
    check("midrst_count", {28'd0, count_a}, 0);
    check("midrst_no_tick", {31'd0, tick_a}, 0);
    check("midrst_b_state", {30'd0, state_b}, 0);
    wait_until(s + 20220);
    check("expected_ticks_consumed", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/exec_step_controller.md
Name: exec_step_controller

Overview:
Owns the processor's execution timing. It turns the 50 MHz physical_clock into single-cycle cpu_tick enables, at a rate chosen by the r_clk speed code. It also sequences reset-init, run, halt and single-step, taking commands from the debounced front-panel keys and the decoded HALT instruction. It replaces the free-running divided clock feeding ProgramCounter, Registers, NStacks and NDMA. Those blocks qualify their logic with cpu_tick and init_flag on physical_clock.

Parameters:
CNT_W, 32, width of retired-tick counter cycle_count
AUTO_RUN, 1, 1 = leave INIT into RUNNING; 0 = leave INIT into HALTED
DIV0, 16, physical_clock cycles per tick for speed code 0
DIV1, 50000, cycles per tick for speed code 1
DIV2, 500000, cycles per tick for speed code 2
DIV3, 5000000, cycles per tick for speed code 3
DIV4, 50000000, cycles per tick for speed codes 4..15

Ports:
physical_clock  input  1  system clock, 50 MHz, sole clock
n_reset  input  1  synchronous, active-low reset
speed_sel  input  4  speed code (r_clk register)
run_req  input  1  level from debouncer; rising edge = run
halt_req  input  1  level from debouncer; rising edge = halt
step_req  input  1  level from debouncer; rising edge = single step
halt_instr  input  1  decoder flags HALT as the current instruction
cpu_tick  output  1  one-cycle execution enable
init_flag  output  1  0 until the init tick has been issued, then 1
state  output  2  0 INIT, 1 HALTED, 2 RUNNING, 3 STEP
cycle_count  output  CNT_W  number of ticks issued, wraps

Behaviour:
- Reset (n_reset=0 at a physical_clock edge):
  - state=INIT, cpu_tick=0, init_flag=0, cycle_count=0, div_cnt=0.
  - Edge-detect history registers are loaded with the current inputs, so a key held through reset produces no edge.
  - Reset mid-operation aborts any count and any pending tick immediately.
- All outputs are registered.
- period = DIVn selected by speed_sel. Codes 4..15 map to DIV4. period is recomputed every cycle.
- INIT:
  - First cycle after reset release: cpu_tick=1. This is the init tick; it is not counted.
  - Next cycle: init_flag=1 and state goes to RUNNING (AUTO_RUN=1) or HALTED (AUTO_RUN=0), with div_cnt=0.
  - Edges are ignored in INIT.
- RUNNING:
  - div_cnt increments each cycle.
  - When div_cnt >= period-1: cpu_tick=1 on the next cycle, div_cnt=0, cycle_count+1.
  - Using >= means a faster speed code applied mid-count ticks on the next cycle and never overflows.
  - halt_req edge has priority over a due tick. On the next cycle: state=HALTED, div_cnt=0, no tick.
  - halt_instr is sampled only in the cycle cpu_tick=1. If high, that tick stands and state becomes HALTED on the next cycle.
  - step_req and run_req edges are ignored.
- HALTED:
  - run_req edge: state=RUNNING, div_cnt=0. The first tick arrives `period` cycles after entry.
  - step_req edge: state=STEP.
  - If both edges arrive in the same cycle, run wins.
  - halt_req is ignored.
- STEP:
  - Exactly one cycle, with cpu_tick=1 and cycle_count+1. Then state=HALTED unconditionally.
  - halt_instr is irrelevant here.
  - A halt_req edge during STEP is ignored.
- cpu_tick is never high two consecutive cycles, except INIT tick followed by a STEP/RUNNING tick, which the design makes unreachable (min one cycle gap).
- cycle_count wraps from 2^CNT_W-1 to 0 with no flag.
- Ticks never occur while n_reset=0.

Decomposition:
- Package exec_ctrl_pkg:
  - state enum (INIT/HALTED/RUNNING/STEP, 2-bit encodings as above)
  - default DIV constants
  - the speed-code-to-period function
- One sub-module, rise_detect: a 1-bit registered rising-edge detector with synchronous active-low reset that loads history from the input. It is instantiated three times (run, halt, step).

Test Plan:
1. Reset with AUTO_RUN=1, speed_sel=0, hold 3 cycles then release. Required: cpu_tick at cycle 1 after release, init_flag=1 at cycle 2, state=2. Subsequent ticks every 16 cycles; cycle_count=4 after the 4th run tick.
2. Running at speed 0: pulse halt_req in the cycle before a due tick. Required: no tick, state=1, cycle_count unchanged. A step_req edge then gives exactly one tick and state returns to 1 after 1 cycle.
3. Running: assert halt_instr coincident with a tick. Required: that tick is issued, state=1 next cycle, no further ticks for 1000 cycles.
4. Running at speed 1: once div_cnt=20000, switch speed_sel to 0. Required: tick on the next cycle, then every 16 cycles. Speed_sel=9 behaves as DIV4; use override DIV4=32 in the bench.
5. HALTED with run_req and step_req rising in the same cycle. Required: state=2, no STEP-state tick, first tick 16 cycles later. step_req held high through reset produces no step after release.
6. CNT_W=4, run 17 ticks. Required: cycle_count wraps to 1. Assert n_reset=0 mid-count: next cycle state=0, init_flag=0, cycle_count=0, no tick.
